// File: rtl/alu_frame_pkg.sv
// Shared types, constants and the serial CRC4 step for the ALU frame receiver.
// Used by both the RTL and the bench model.
package alu_frame_pkg;

   typedef enum logic [2:0] {
      OpAnd = 3'b000,
      OpOr  = 3'b001,
      OpAdd = 3'b100,
      OpSub = 3'b101
   } operation_t;

   localparam int unsigned WORD_BITS = 11;
   localparam logic        TYPE_DATA = 1'b0;
   localparam logic        TYPE_CTL  = 1'b1;
   localparam logic [3:0]  CRC_POLY  = 4'b0011;

   typedef enum logic [1:0] {
      StIdle,
      StType,
      StPayload,
      StStop
   } word_state_t;

   typedef enum logic {
      FrCollect,
      FrDone
   } frame_state_t;

   // x^4+x+1, MSB-first, one bit at a time
   function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
      logic fb;
      fb = crc[3] ^ din;
      return {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
   endfunction

endpackage

// File: rtl/alu_word_rx.sv
// 11-bit word deserializer: start, type, 8 payload bits MSB first, stop.
// With ALU_FRAME_RX_TIMEOUT_EN defined it also exposes an idle indication.
module alu_word_rx
   import alu_frame_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
`ifdef ALU_FRAME_RX_TIMEOUT_EN
   output logic       idle,
`endif
   output logic       word_valid,
   output logic       word_type,
   output logic [7:0] word_byte,
   output logic       stop_err
);

   word_state_t state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        type_q, type_d;
   logic        valid_q, valid_d;
   logic        stop_err_q, stop_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         type_q     <= 1'b0;
         valid_q    <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         type_q     <= type_d;
         valid_q    <= valid_d;
         stop_err_q <= stop_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      type_d     = type_q;
      valid_d    = 1'b0;
      stop_err_d = stop_err_q;
      unique case (state_q)
         StIdle: begin
            if (!sin) state_d = StType;
         end
         StType: begin
            type_d    = sin;
            bit_cnt_d = 3'd7;
            state_d   = StPayload;
         end
         StPayload: begin
            shift_d   = {shift_q[6:0], sin};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) state_d = StStop;
         end
         StStop: begin
            valid_d    = 1'b1;
            stop_err_d = ~sin;
            state_d    = StIdle;
         end
      endcase
   end

   // Byte and type stay put until the next word is well under way.
   assign word_valid = valid_q;
   assign word_type  = type_q;
   assign word_byte  = shift_q;
   assign stop_err   = stop_err_q;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
   assign idle       = (state_q == StIdle);
`endif

endmodule

// File: rtl/alu_frame_rx.sv
// ALU serial command receiver: word count, CRC4 and a one-entry output buffer.
// Define ALU_FRAME_RX_TIMEOUT_EN to flush partial frames after TIMEOUT_CYCLES idle.
module alu_frame_rx
   import alu_frame_pkg::*;
#(
   parameter int unsigned NUM_OPERANDS   = 2,
   parameter int unsigned OPERAND_BYTES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   sin,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [NUM_OPERANDS*OPERAND_BYTES*8-1:0] out_operands,
   output logic [2:0]                             out_op,
   output logic                                   out_err_crc,
   output logic                                   out_err_data,
   output logic                                   out_err_frame,
   output logic                                   overflow
);

   localparam int unsigned NumBytes = NUM_OPERANDS * OPERAND_BYTES;
   localparam int unsigned DataW    = NumBytes * 8;
   localparam int unsigned CntW     = $clog2(NumBytes + 2);
   localparam logic [CntW-1:0] CntFull = CntW'(NumBytes);
   localparam logic [CntW-1:0] CntMax  = CntW'(NumBytes + 1);

   logic       word_valid, word_type, stop_err;
   logic [7:0] word_byte;

   frame_state_t    state_q, state_d;
   logic [DataW-1:0] data_q, data_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      crc_q, crc_d, crc_calc;
   logic            ferr_q, ferr_d;
   logic [2:0]      pend_op_q, pend_op_d;
   logic            pend_crc_q, pend_crc_d;
   logic            pend_data_q, pend_data_d;
   logic            pend_frame_q, pend_frame_d;

   logic             out_valid_q, out_valid_d;
   logic [DataW-1:0] ops_q, ops_d;
   logic [2:0]       op_q, op_d;
   logic             err_crc_q, err_crc_d;
   logic             err_data_q, err_data_d;
   logic             err_frame_q, err_frame_d;
   logic             overflow_q, overflow_d;

`ifdef ALU_FRAME_RX_TIMEOUT_EN
   localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);
   logic            word_idle;
   logic [GapW-1:0] gap_q, gap_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   alu_word_rx u_word_rx (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
`ifdef ALU_FRAME_RX_TIMEOUT_EN
      .idle       (word_idle),
`endif
      .word_valid (word_valid),
      .word_type  (word_type),
      .word_byte  (word_byte),
      .stop_err   (stop_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FrCollect;
         data_q       <= '0;
         cnt_q        <= '0;
         crc_q        <= '0;
         ferr_q       <= 1'b0;
         pend_op_q    <= '0;
         pend_crc_q   <= 1'b0;
         pend_data_q  <= 1'b0;
         pend_frame_q <= 1'b0;
         out_valid_q  <= 1'b0;
         ops_q        <= '0;
         op_q         <= '0;
         err_crc_q    <= 1'b0;
         err_data_q   <= 1'b0;
         err_frame_q  <= 1'b0;
         overflow_q   <= 1'b0;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
         gap_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         crc_q        <= crc_d;
         ferr_q       <= ferr_d;
         pend_op_q    <= pend_op_d;
         pend_crc_q   <= pend_crc_d;
         pend_data_q  <= pend_data_d;
         pend_frame_q <= pend_frame_d;
         out_valid_q  <= out_valid_d;
         ops_q        <= ops_d;
         op_q         <= op_d;
         err_crc_q    <= err_crc_d;
         err_data_q   <= err_data_d;
         err_frame_q  <= err_frame_d;
         overflow_q   <= overflow_d;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
         gap_q        <= gap_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      crc_calc     = crc_q;
      ferr_d       = ferr_q;
      pend_op_d    = pend_op_q;
      pend_crc_d   = pend_crc_q;
      pend_data_d  = pend_data_q;
      pend_frame_d = pend_frame_q;
      out_valid_d  = out_valid_q;
      ops_d        = ops_q;
      op_d         = op_q;
      err_crc_d    = err_crc_q;
      err_data_d   = err_data_q;
      err_frame_d  = err_frame_q;
      overflow_d   = 1'b0;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
      gap_d        = gap_q;
`endif

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      unique case (state_q)
         FrCollect: begin
            if (word_valid && (word_type == TYPE_DATA)) begin
               ferr_d = ferr_q | stop_err;
               // Only bytes that are stored contribute to the CRC.
               if (cnt_q < CntFull) begin
                  for (int unsigned o = 0; o < NUM_OPERANDS; o++) begin
                     for (int unsigned b = 0; b < OPERAND_BYTES; b++) begin
                        if (cnt_q == CntW'(o * OPERAND_BYTES + b)) begin
                           data_d[(o * OPERAND_BYTES + OPERAND_BYTES - 1 - b) * 8 +: 8] = word_byte;
                        end
                     end
                  end
                  for (int i = 7; i >= 0; i--) crc_calc = crc4_step(crc_calc, word_byte[i]);
                  crc_d = crc_calc;
               end
               if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
            end else if (word_valid) begin
               crc_calc = crc4_step(crc_q, 1'b1);
               for (int i = 6; i >= 4; i--) crc_calc = crc4_step(crc_calc, word_byte[i]);
               pend_op_d    = word_byte[6:4];
               pend_data_d  = (cnt_q != CntFull) || word_byte[7];
               pend_crc_d   = !pend_data_d && (word_byte[3:0] != crc_calc);
               pend_frame_d = ferr_q | stop_err;
               state_d      = FrDone;
            end
`ifdef ALU_FRAME_RX_TIMEOUT_EN
            gap_d = '0;
            if (!word_valid && word_idle && (cnt_q != '0)) begin
               gap_d = gap_q + GapW'(1);
               if (gap_d == GapW'(TIMEOUT_CYCLES)) begin
                  pend_op_d    = '0;
                  pend_data_d  = 1'b1;
                  pend_crc_d   = 1'b0;
                  pend_frame_d = ferr_q;
                  state_d      = FrDone;
               end
            end
`endif
         end
         FrDone: begin
            // Accept-and-reload keeps out_valid high across the swap.
            if (!out_valid_q || out_ready) begin
               out_valid_d = 1'b1;
               ops_d       = data_q;
               op_d        = pend_op_q;
               err_crc_d   = pend_crc_q;
               err_data_d  = pend_data_q;
               err_frame_d = pend_frame_q;
            end else begin
               overflow_d = 1'b1;
            end
            data_d  = '0;
            cnt_d   = '0;
            crc_d   = '0;
            ferr_d  = 1'b0;
            state_d = FrCollect;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
            gap_d   = '0;
`endif
         end
      endcase
   end

   assign out_valid     = out_valid_q;
   assign out_operands  = ops_q;
   assign out_op        = op_q;
   assign out_err_crc   = err_crc_q;
   assign out_err_data  = err_data_q;
   assign out_err_frame = err_frame_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_alu_frame_rx.sv
// Directed bench for alu_frame_rx with an expected-result queue.
module tb_alu_frame_rx;
   import alu_frame_pkg::*;

   typedef struct packed {
      logic [63:0] ops;
      logic [2:0]  op;
      logic        e_crc;
      logic        e_data;
      logic        e_frame;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sin;
   logic        out_ready;
   logic        out_valid;
   logic [63:0] out_operands;
   logic [2:0]  out_op;
   logic        out_err_crc;
   logic        out_err_data;
   logic        out_err_frame;
   logic        overflow;

   int   checks = 0;
   int   errors = 0;
   int   ovf_seen = 0;
   exp_t q[$];
   exp_t cur;
   logic [7:0]  fb [16];
   logic        hold_prev = 1'b0;
   logic [63:0] snap_ops;
   logic [5:0]  snap_f;

   alu_frame_rx dut (
      .clk           (clk),
      .rst           (rst),
      .sin           (sin),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_operands  (out_operands),
      .out_op        (out_op),
      .out_err_crc   (out_err_crc),
      .out_err_data  (out_err_data),
      .out_err_frame (out_err_frame),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk_exp(input logic [63:0] ops, input logic [2:0] op,
                                   input logic c, input logic d, input logic f);
      exp_t e;
      e.ops = ops; e.op = op; e.e_crc = c; e.e_data = d; e.e_frame = f;
      return e;
   endfunction

   function automatic logic [3:0] model_crc(input int n, input logic [2:0] op);
      logic [3:0] c;
      c = 4'b0000;
      for (int i = 0; i < n && i < 8; i++)
         for (int b = 7; b >= 0; b--) c = crc4_step(c, fb[i][b]);
      c = crc4_step(c, 1'b1);
      for (int b = 2; b >= 0; b--) c = crc4_step(c, op[b]);
      return c;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk);
      sin = b;
   endtask

   task automatic idle(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   task automatic send_word(input logic t, input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      send_bit(t);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic send_frame(input int n, input logic [2:0] op, input logic [3:0] crc,
                             input logic b7, input int bad_stop, input int gap_max,
                             input logic push, input exp_t e);
      if (push) q.push_back(e);
      for (int i = 0; i < n; i++) begin
         send_word(TYPE_DATA, fb[i], (i != bad_stop));
         idle(int'($urandom_range(gap_max, 0)));
      end
      send_word(TYPE_CTL, {b7, op, crc}, 1'b1);
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(q.size()), 64'd0);
      idle(3);
   endtask

   // Output monitor: pops on every accepted command, checks hold stability.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (overflow === 1'b1) ovf_seen++;
         if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ops", out_operands, snap_ops);
            check("hold_fields", 64'({out_op, out_err_crc, out_err_data, out_err_frame}),
                  64'(snap_f));
         end
         if (out_valid && out_ready) begin
            check("valid_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               cur = q.pop_front();
               check("operands", out_operands, cur.ops);
               check("op", 64'(out_op), 64'(cur.op));
               check("err_crc", 64'(out_err_crc), 64'(cur.e_crc));
               check("err_data", 64'(out_err_data), 64'(cur.e_data));
               check("err_frame", 64'(out_err_frame), 64'(cur.e_frame));
            end
         end
         hold_prev <= out_valid && !out_ready;
         snap_ops  <= out_operands;
         snap_f    <= {out_op, out_err_crc, out_err_data, out_err_frame};
      end
   end

   initial begin
      rst = 1'b1;
      sin = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ops", out_operands, 64'd0);
      check("rst_flags", 64'({out_op, out_err_crc, out_err_data, out_err_frame, overflow}), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      idle(3);

      // Default all-zero frame with its correct CRC
      for (int i = 0; i < 16; i++) fb[i] = 8'h00;
      send_frame(8, 3'b000, 4'b1011, 1'b0, -1, 0, 1'b1, mk_exp(64'd0, 3'b000, 0, 0, 0));
      wait_drain("drain_default");

      // B then A with random idle gaps
      fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
      for (int i = 4; i < 8; i++) fb[i] = 8'hA5;
      send_frame(8, 3'b100, model_crc(8, 3'b100), 1'b0, -1, 5, 1'b1,
                 mk_exp(64'hA5A5A5A5_01020304, 3'b100, 0, 0, 0));
      wait_drain("drain_ab");

      // Bad CRC
      for (int i = 0; i < 16; i++) fb[i] = 8'h00;
      send_frame(8, 3'b000, 4'b0000, 1'b0, -1, 0, 1'b1, mk_exp(64'd0, 3'b000, 1, 0, 0));
      wait_drain("drain_badcrc");

      // Short frame: 7 data words, last byte position reads 0
      for (int i = 0; i < 7; i++) fb[i] = 8'h11 + 8'(i);
      send_frame(7, 3'b001, 4'b0000, 1'b0, -1, 0, 1'b1,
                 mk_exp(64'h15161700_11121314, 3'b001, 0, 1, 0));
      wait_drain("drain_short");

      // Long frame: 9 data words, ninth byte discarded
      for (int i = 0; i < 9; i++) fb[i] = 8'h21 + 8'(i);
      send_frame(9, 3'b101, model_crc(8, 3'b101), 1'b0, -1, 0, 1'b1,
                 mk_exp(64'h25262728_21222324, 3'b101, 0, 1, 0));
      wait_drain("drain_long");

      // Control payload bit7 set
      for (int i = 0; i < 16; i++) fb[i] = 8'h00;
      send_frame(8, 3'b000, 4'b1011, 1'b1, -1, 0, 1'b1, mk_exp(64'd0, 3'b000, 0, 1, 0));
      wait_drain("drain_b7");

      // Stop bit of word 3 low: framing error, data intact
      for (int i = 0; i < 8; i++) fb[i] = 8'hC0 + 8'(i);
      send_frame(8, 3'b101, model_crc(8, 3'b101), 1'b0, 3, 0, 1'b1,
                 mk_exp(64'hC4C5C6C7_C0C1C2C3, 3'b101, 0, 0, 1));
      wait_drain("drain_frame");

      // Two frames with out_ready low: first held, second dropped
      @(posedge clk); #1 out_ready = 1'b0;
      for (int i = 0; i < 8; i++) fb[i] = 8'h01 + 8'(i);
      send_frame(8, 3'b001, model_crc(8, 3'b001), 1'b0, -1, 0, 1'b1,
                 mk_exp(64'h05060708_01020304, 3'b001, 0, 0, 0));
      for (int i = 0; i < 8; i++) fb[i] = 8'hF0 + 8'(i);
      send_frame(8, 3'b000, model_crc(8, 3'b000), 1'b0, -1, 0, 1'b0,
                 mk_exp(64'd0, 3'b000, 0, 0, 0));
      idle(6);
      check("held_valid", 64'(out_valid), 64'd1);
      check("held_ops", out_operands, 64'h05060708_01020304);
      check("overflow_once", 64'(ovf_seen), 64'd1);

      // Third frame, reset mid-word: held frame and partial frame both discarded
      send_word(TYPE_DATA, 8'h55, 1'b1);
      send_word(TYPE_DATA, 8'h66, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_ops", out_operands, 64'd0);
      check("midrst_flags",
            64'({out_op, out_err_crc, out_err_data, out_err_frame, overflow}), 64'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      idle(40);
      check("no_spurious_valid", 64'(out_valid), 64'd0);

      // Recovery after reset
      for (int i = 0; i < 16; i++) fb[i] = 8'h00;
      send_frame(8, 3'b000, 4'b1011, 1'b0, -1, 0, 1'b1, mk_exp(64'd0, 3'b000, 0, 0, 0));
      wait_drain("drain_recover");

`ifdef ALU_FRAME_RX_TIMEOUT_EN
      fb[0] = 8'h31; fb[1] = 8'h32; fb[2] = 8'h33;
      q.push_back(mk_exp(64'h00000000_31323300, 3'b000, 0, 1, 0));
      for (int i = 0; i < 3; i++) send_word(TYPE_DATA, fb[i], 1'b1);
      idle(80);
      wait_drain("drain_timeout");
`endif

      check("overflow_total", 64'(ovf_seen), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
